seq_mag_comp: RTL and testbench
===============================

SEQ_MAG_COMP -- requirements
Module: seq_mag_comp

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high; the ports SHALL be named clk and reset.
REQ-002 Parameter WIDTH, default 16, operand width in bits.
REQ-003 Parameter CHUNK, default 2, bits compared per cycle; WIDTH SHALL be a multiple of CHUNK, and NCHUNK = WIDTH/CHUNK.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 start  in  1  request a comparison; sampled only in IDLE.
REQ-007 signed_mode  in  1  1 = two's-complement compare, 0 = unsigned; latched with the operands.
REQ-008 a  in  WIDTH  operand A; latched on accepted start.
REQ-009 b  in  WIDTH  operand B; latched on accepted start.
REQ-010 busy  out  1  high in COMPARE and DONE.
REQ-011 done  out  1  one-cycle pulse when the result flags update.
REQ-012 agtb / aeqb / altb  out  1 each  registered result flags for A>B, A==B, A<B.

Function
REQ-013 FSM states SHALL be IDLE, COMPARE and DONE.
REQ-014 IDLE with start=1 at a clock edge SHALL latch a, b and signed_mode, set chunk index to NCHUNK-1, and go to COMPARE.
REQ-015 In signed mode the block SHALL invert the MSB of both latched operands, which reduces the signed compare to an unsigned compare.
REQ-016 Each COMPARE cycle SHALL compare the latched chunk at the index, taking chunks MSB-first.
- Chunks differ: record gt or lt and go to DONE (early exit).
- Chunks equal and index = 0: record eq and go to DONE.
- Otherwise: decrement the index and stay in COMPARE.
REQ-017 On entry to DONE the block SHALL update agtb/aeqb/altb, with exactly one flag high, and pulse done for that single DONE cycle; the next state SHALL be IDLE.
REQ-018 Latency: with start accepted in cycle 0 and m chunks examined (1 ≤ m ≤ NCHUNK), done SHALL be high in cycle m+1.
- Worst case is NCHUNK+1 cycles.
- The next start SHALL be accepted no earlier than cycle m+2.
REQ-019 The result flags SHALL hold their value until the next DONE entry or reset.
REQ-020 The block SHALL ignore start in COMPARE and DONE, and SHALL ignore changes on a, b and signed_mode while busy.
REQ-021 start held high continuously SHALL produce back-to-back comparisons, each re-latching its operands in IDLE.

Reset
REQ-022 reset SHALL have priority over all other inputs; reset SHALL force IDLE and clear busy, done, agtb, aeqb, altb, the chunk index and the latched operands to 0.
REQ-023 reset asserted during COMPARE or DONE SHALL abort the comparison without a done pulse; the flags SHALL read 0 until the next completed comparison.

Structure
REQ-024 The state encoding (IDLE/COMPARE/DONE) and the default WIDTH/CHUNK constants SHALL live in shared package comp_pkg.
REQ-025 The per-chunk compare SHALL be a combinational sub-module chunk_cmp (parameter CHUNK; outputs gt, eq), instantiated once.
REQ-026 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Verification (WIDTH=16, CHUNK=2, NCHUNK=8)
REQ-027 Unsigned, a=0x8000, b=0x7FFF, start in cycle 0 -> agtb=1 and done=1 in cycle 2 (early exit at the top chunk).
REQ-028 Signed, a=0xFFFF, b=0x0000 -> altb=1 in cycle 2; the same operands unsigned -> agtb=1 in cycle 2.
REQ-029 a=b=0x1234 -> aeqb=1 and done in cycle 9; a=0x1235, b=0x1234 -> agtb=1 and done in cycle 9.
REQ-030 Start a=0x0001, b=0x0002, then assert reset in cycle 4 -> done never pulses and busy/flags read 0 from cycle 5; a fresh start then completes normally.
REQ-031 Change a/b mid-compare and pulse start while busy -> the result reflects the originally latched operands and no extra comparison occurs; start held high -> consecutive done pulses spaced m+2 cycles apart.

Source files
------------

// File: rtl/comp_pkg.sv
// rtl/comp_pkg.sv - shared state encoding and default sizes for the sequential comparator
package comp_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/chunk_cmp.sv
// rtl/chunk_cmp.sv - combinational unsigned compare of one operand chunk
module chunk_cmp #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             gt,
    output logic             eq
);

    assign gt = (a > b);
    assign eq = (a == b);

endmodule

// File: rtl/seq_mag_comp.sv
// rtl/seq_mag_comp.sv - multi-cycle magnitude comparator, MSB-first chunk scan with early exit
module seq_mag_comp
    import comp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             agtb,
    output logic             aeqb,
    output logic             altb
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

    state_t            state;
    logic [IDXW-1:0]   idx;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  msb_flip;
    logic [CHUNK-1:0]  a_chunk;
    logic [CHUNK-1:0]  b_chunk;
    logic              chunk_gt;
    logic              chunk_eq;

    // Flipping both sign bits maps two's-complement order onto unsigned order.
    assign msb_flip = {signed_mode, {(WIDTH-1){1'b0}}};

    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx == i[IDXW-1:0]) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    chunk_cmp #(
        .CHUNK (CHUNK)
    ) u_chunk_cmp (
        .a  (a_chunk),
        .b  (b_chunk),
        .gt (chunk_gt),
        .eq (chunk_eq)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            idx   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            agtb  <= 1'b0;
            aeqb  <= 1'b0;
            altb  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= a ^ msb_flip;
                        b_q   <= b ^ msb_flip;
                        idx   <= IDX_TOP;
                        busy  <= 1'b1;
                        state <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (!chunk_eq) begin
                        agtb  <= chunk_gt;
                        aeqb  <= 1'b0;
                        altb  <= !chunk_gt;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else if (idx == '0) begin
                        agtb  <= 1'b0;
                        aeqb  <= 1'b1;
                        altb  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mag_comp.sv
// tb/tb_seq_mag_comp.sv - directed self-checking bench for seq_mag_comp
module tb_seq_mag_comp;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        signed_mode;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic        agtb;
    logic        aeqb;
    logic        altb;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_mag_comp #(
        .WIDTH (16),
        .CHUNK (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .agtb        (agtb),
        .aeqb        (aeqb),
        .altb        (altb)
    );

    // Start in cycle 0 (the edge that samples start); lat is the cycle in which done is seen.
    task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic sm,
                          output int lat, output logic [2:0] fl);
        @(negedge clk);
        a = av; b = bv; signed_mode = sm; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        fl  = 3'bxxx;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = c;
                fl  = {agtb, aeqb, altb};
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, agtb, aeqb, altb} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 00000", {busy, done, agtb, aeqb, altb});
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset: busy/done got %b want 00", {busy, done});
        end
    endtask

    task automatic test_unsigned();
        int lat; logic [2:0] fl;
        run_op(16'h8000, 16'h7FFF, 1'b0, lat, fl);
        checks++;
        if (lat !== 2 || fl !== 3'b100) begin
            errors++;
            $display("FAIL unsigned_top_chunk: lat=%0d flags=%b want lat=2 flags=100", lat, fl);
        end
        run_op(16'h0100, 16'h0200, 1'b0, lat, fl);
        checks++;
        if (lat !== 5 || fl !== 3'b001) begin
            errors++;
            $display("FAIL unsigned_mid_chunk: lat=%0d flags=%b want lat=5 flags=001", lat, fl);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, agtb, aeqb, altb} !== 5'b00001) begin
            errors++;
            $display("FAIL flags_hold: got %b want 00001", {busy, done, agtb, aeqb, altb});
        end
    endtask

    task automatic test_signed();
        int lat; logic [2:0] fl;
        run_op(16'hFFFF, 16'h0000, 1'b1, lat, fl);
        checks++;
        if (lat !== 2 || fl !== 3'b001) begin
            errors++;
            $display("FAIL signed_neg_vs_zero: lat=%0d flags=%b want lat=2 flags=001", lat, fl);
        end
        run_op(16'hFFFF, 16'h0000, 1'b0, lat, fl);
        checks++;
        if (lat !== 2 || fl !== 3'b100) begin
            errors++;
            $display("FAIL unsigned_ffff_vs_zero: lat=%0d flags=%b want lat=2 flags=100", lat, fl);
        end
        run_op(16'h8000, 16'h7FFF, 1'b1, lat, fl);
        checks++;
        if (lat !== 2 || fl !== 3'b001) begin
            errors++;
            $display("FAIL signed_min_vs_max: lat=%0d flags=%b want lat=2 flags=001", lat, fl);
        end
    endtask

    task automatic test_full_scan();
        int lat; logic [2:0] fl;
        run_op(16'h1234, 16'h1234, 1'b0, lat, fl);
        checks++;
        if (lat !== 9 || fl !== 3'b010) begin
            errors++;
            $display("FAIL equal_full_scan: lat=%0d flags=%b want lat=9 flags=010", lat, fl);
        end
        run_op(16'h1235, 16'h1234, 1'b0, lat, fl);
        checks++;
        if (lat !== 9 || fl !== 3'b100) begin
            errors++;
            $display("FAIL lsb_chunk_gt: lat=%0d flags=%b want lat=9 flags=100", lat, fl);
        end
        run_op(16'hC000, 16'hC000, 1'b1, lat, fl);
        checks++;
        if (lat !== 9 || fl !== 3'b010) begin
            errors++;
            $display("FAIL signed_equal: lat=%0d flags=%b want lat=9 flags=010", lat, fl);
        end
    endtask

    task automatic test_reset_abort();
        int lat; logic [2:0] fl; int seen;
        @(negedge clk);
        a = 16'h0001; b = 16'h0002; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, agtb, aeqb, altb} !== 5'b0) begin
            errors++;
            $display("FAIL abort_clears: got %b want 00000", {busy, done, agtb, aeqb, altb});
        end
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0 || {agtb, aeqb, altb} !== 3'b000) begin
            errors++;
            $display("FAIL abort_no_done: activity=%0d flags=%b want 0 and 000", seen, {agtb, aeqb, altb});
        end
        run_op(16'h0001, 16'h0002, 1'b0, lat, fl);
        checks++;
        if (lat !== 9 || fl !== 3'b001) begin
            errors++;
            $display("FAIL restart_after_abort: lat=%0d flags=%b want lat=9 flags=001", lat, fl);
        end
    endtask

    task automatic test_ignore_busy();
        int lat; logic [2:0] fl; int extra;
        @(negedge clk);
        a = 16'h0100; b = 16'h0200; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1; fl = 3'bxxx;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 2) begin
                a = 16'hFFFF; b = 16'h0000; signed_mode = 1'b1; start = 1'b1;
            end else if (c == 3) begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                lat = c; fl = {agtb, aeqb, altb};
                break;
            end
        end
        start = 1'b0;
        checks++;
        if (lat !== 5 || fl !== 3'b001) begin
            errors++;
            $display("FAIL ignore_while_busy: lat=%0d flags=%b want lat=5 flags=001", lat, fl);
        end
        extra = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL no_extra_compare: busy/done cycles=%0d want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int         dcyc[3];
        logic [2:0] dfl[3];
        int         n;
        n = 0;
        for (int i = 0; i < 3; i++) begin dcyc[i] = -1; dfl[i] = 3'bxxx; end
        @(negedge clk);
        a = 16'h8000; b = 16'h7FFF; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) begin a = 16'h0001; b = 16'h0002; end
            if (done === 1'b1 && n < 3) begin
                dcyc[n] = c; dfl[n] = {agtb, aeqb, altb};
                n++;
            end
        end
        start = 1'b0;
        checks++;
        if (dcyc[0] !== 2 || dfl[0] !== 3'b100) begin
            errors++;
            $display("FAIL b2b_first: cycle=%0d flags=%b want cycle=2 flags=100", dcyc[0], dfl[0]);
        end
        checks++;
        if (dcyc[1] !== 12 || dfl[1] !== 3'b001) begin
            errors++;
            $display("FAIL b2b_second: cycle=%0d flags=%b want cycle=12 flags=001", dcyc[1], dfl[1]);
        end
        checks++;
        if (dcyc[2] !== 22 || dfl[2] !== 3'b001) begin
            errors++;
            $display("FAIL b2b_third: cycle=%0d flags=%b want cycle=22 flags=001", dcyc[2], dfl[2]);
        end
        repeat (12) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_full_scan();
        test_reset_abort();
        test_ignore_busy();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
